// File: rtl/washer_color_classifier_pkg.sv
// Shared colour codes, filter selects and FSM encoding for the washer colour path.
// COLOR_CLEAR_GATE_EN adds the unfiltered clear-photodiode window.
package washer_color_classifier_pkg;

  localparam logic [2:0] COLOR_RED     = 3'b000;
  localparam logic [2:0] COLOR_BLUE    = 3'b001;
  localparam logic [2:0] COLOR_GREEN   = 3'b010;
  localparam logic [2:0] COLOR_YELLOW  = 3'b011;
  localparam logic [2:0] COLOR_UNKNOWN = 3'b100;

  // {S2,S3} filter selects
  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_GREEN = 2'b11;
  localparam logic [1:0] FILT_CLEAR = 2'b10;
  localparam logic [1:0] FILT_OFF   = 2'b00;

  typedef enum logic [3:0] {
    IDLE,
    SEL_R,
    CNT_R,
    SEL_B,
    CNT_B,
    SEL_G,
    CNT_G,
`ifdef COLOR_CLEAR_GATE_EN
    SEL_C,
    CNT_C,
`endif
    CLASSIFY,
    DONE
  } state_t;

endpackage

// File: rtl/washer_color_classifier_pulse_edge_counter.sv
// Sensor pulse synchronizer, rising-edge detector and saturating
// window counter with synchronous clear and count enable.
module pulse_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic             pulse,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  logic [2:0] syncQ;
  logic       edgeHit;

  always_ff @(posedge CLK100MHZ) begin
    if (!reset) syncQ <= '0;
    else        syncQ <= {syncQ[1:0], pulse};
  end

  assign edgeHit = syncQ[1] & ~syncQ[2];

  always_ff @(posedge CLK100MHZ) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (enable && edgeHit && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/washer_color_classifier.sv
// Washer colour classifier: steps the sensor filters, counts pulses per window.
// Define COLOR_CLEAR_GATE_EN to add a clear-channel window and brightness gate.
module washer_color_classifier
  import washer_color_classifier_pkg::*;
#(
  parameter int GATE_CYCLES   = 1000000,
  parameter int SETTLE_CYCLES = 10000,
  parameter int CNT_W         = 16,
  parameter int MIN_COUNT     = 200
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic             start,
  input  logic             colorSensorPulse,
  output logic             colorSensor_S2,
  output logic             colorSensor_S3,
  output logic             busy,
  output logic             done,
  output logic [2:0]       color,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt
);

  localparam int WW = CNT_W + 2;
  localparam int TMR_MAX =
    (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);

  state_t           state;
  state_t           stateNext;
  logic [TMR_W-1:0] timer;
  logic             inSel;
  logic             inCnt;
  logic             settleDone;
  logic             gateDone;
  logic [1:0]       filt;

  logic [CNT_W-1:0] rCnt;
  logic [CNT_W-1:0] gCnt;
  logic [CNT_W-1:0] bCnt;
  logic [WW-1:0]    rW;
  logic [WW-1:0]    gW;
  logic [WW-1:0]    bW;
  logic [WW-1:0]    maxW;
  logic [2:0]       classColor;

  logic [2:0]       colorQ;
  logic [CNT_W-1:0] redQ;
  logic [CNT_W-1:0] greenQ;
  logic [CNT_W-1:0] blueQ;

  always_ff @(posedge CLK100MHZ) begin
    if (!reset) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= stateNext;
      if (stateNext != state)  timer <= '0;
      else if (inSel || inCnt) timer <= timer + 1'b1;
    end
  end

  always_comb begin
    filt  = FILT_OFF;
    inSel = 1'b0;
    inCnt = 1'b0;
    case (state)
      SEL_R: begin filt = FILT_RED;   inSel = 1'b1; end
      CNT_R: begin filt = FILT_RED;   inCnt = 1'b1; end
      SEL_B: begin filt = FILT_BLUE;  inSel = 1'b1; end
      CNT_B: begin filt = FILT_BLUE;  inCnt = 1'b1; end
      SEL_G: begin filt = FILT_GREEN; inSel = 1'b1; end
      CNT_G: begin filt = FILT_GREEN; inCnt = 1'b1; end
`ifdef COLOR_CLEAR_GATE_EN
      SEL_C: begin filt = FILT_CLEAR; inSel = 1'b1; end
      CNT_C: begin filt = FILT_CLEAR; inCnt = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign settleDone = inSel && (timer == SETTLE_LAST);
  assign gateDone   = inCnt && (timer == GATE_LAST);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (start)      stateNext = SEL_R;
      SEL_R:    if (settleDone) stateNext = CNT_R;
      CNT_R:    if (gateDone)   stateNext = SEL_B;
      SEL_B:    if (settleDone) stateNext = CNT_B;
      CNT_B:    if (gateDone)   stateNext = SEL_G;
      SEL_G:    if (settleDone) stateNext = CNT_G;
`ifdef COLOR_CLEAR_GATE_EN
      CNT_G:    if (gateDone)   stateNext = SEL_C;
      SEL_C:    if (settleDone) stateNext = CNT_C;
      CNT_C:    if (gateDone)   stateNext = CLASSIFY;
`else
      CNT_G:    if (gateDone)   stateNext = CLASSIFY;
`endif
      CLASSIFY: stateNext = DONE;
      DONE:     stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  assign {colorSensor_S2, colorSensor_S3} = filt;
  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  pulse_edge_counter #(.CNT_W(CNT_W)) uRedCnt (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .pulse     (colorSensorPulse),
    .clear     (state == SEL_R),
    .enable    (state == CNT_R),
    .count     (rCnt)
  );

  pulse_edge_counter #(.CNT_W(CNT_W)) uBlueCnt (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .pulse     (colorSensorPulse),
    .clear     (state == SEL_B),
    .enable    (state == CNT_B),
    .count     (bCnt)
  );

  pulse_edge_counter #(.CNT_W(CNT_W)) uGreenCnt (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .pulse     (colorSensorPulse),
    .clear     (state == SEL_G),
    .enable    (state == CNT_G),
    .count     (gCnt)
  );

`ifdef COLOR_CLEAR_GATE_EN
  logic [CNT_W-1:0] cCnt;
  logic [WW-1:0]    cW;

  pulse_edge_counter #(.CNT_W(CNT_W)) uClearCnt (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .pulse     (colorSensorPulse),
    .clear     (state == SEL_C),
    .enable    (state == CNT_C),
    .count     (cCnt)
  );

  assign cW = WW'(cCnt);
`endif

  // Two spare bits keep 4g and 3r exact without overflow
  always_comb begin
    rW   = WW'(rCnt);
    gW   = WW'(gCnt);
    bW   = WW'(bCnt);
    maxW = rW;
    if (gW > maxW) maxW = gW;
    if (bW > maxW) maxW = bW;
    classColor = COLOR_UNKNOWN;
    if (maxW < WW'(MIN_COUNT))
      classColor = COLOR_UNKNOWN;
    else if ((rW >= (bW << 1)) && (gW >= (bW << 1)) &&
             ((gW << 2) >= (rW + (rW << 1))))
      classColor = COLOR_YELLOW;
    else if ((rW > gW) && (rW > bW))
      classColor = COLOR_RED;
    else if ((bW > rW) && (bW > gW))
      classColor = COLOR_BLUE;
    else if ((gW > rW) && (gW > bW))
      classColor = COLOR_GREEN;
    else
      classColor = COLOR_UNKNOWN;
`ifdef COLOR_CLEAR_GATE_EN
    if (cW < WW'(2 * MIN_COUNT)) classColor = COLOR_UNKNOWN;
`endif
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!reset) begin
      colorQ <= COLOR_UNKNOWN;
      redQ   <= '0;
      greenQ <= '0;
      blueQ  <= '0;
    end else if (state == CLASSIFY) begin
      colorQ <= classColor;
      redQ   <= rCnt;
      greenQ <= gCnt;
      blueQ  <= bCnt;
    end
  end

  assign color     = colorQ;
  assign red_cnt   = redQ;
  assign green_cnt = greenQ;
  assign blue_cnt  = blueQ;

endmodule
